// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, fixed latency of DATA_WIDTH+2 edges.
// Define DIV_SIGNED_EN to honour signed_op; otherwise every divide is unsigned.
module seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dvdIn_q, dvdIn_d;
  logic [DATA_WIDTH-1:0] dvsIn_q, dvsIn_d;
  logic [DATA_WIDTH-1:0] dvsMag_q, dvsMag_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic [DATA_WIDTH:0]   remShift;

`ifdef DIV_SIGNED_EN
  logic signedOp_q, signedOp_d;
  logic qNeg_q, qNeg_d;
  logic rNeg_q, rNeg_d;
`else
  logic unusedSignedOp;
  assign unusedSignedOp = signed_op;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= IDLE;
      count_q     <= '0;
      dvdIn_q     <= '0;
      dvsIn_q     <= '0;
      dvsMag_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      signedOp_q  <= 1'b0;
      qNeg_q      <= 1'b0;
      rNeg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvdIn_q     <= dvdIn_d;
      dvsIn_q     <= dvsIn_d;
      dvsMag_q    <= dvsMag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      signedOp_q  <= signedOp_d;
      qNeg_q      <= qNeg_d;
      rNeg_q      <= rNeg_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    dvdIn_d     = dvdIn_q;
    dvsIn_d     = dvsIn_q;
    dvsMag_d    = dvsMag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    remShift    = {rem_q, quo_q[DATA_WIDTH-1]};
`ifdef DIV_SIGNED_EN
    signedOp_d  = signedOp_q;
    qNeg_d      = qNeg_q;
    rNeg_d      = rNeg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          dvdIn_d = dividend;
          dvsIn_d = divisor;
`ifdef DIV_SIGNED_EN
          signedOp_d = signed_op;
`endif
          state_d = PREP;
        end
      end
      PREP: begin
`ifdef DIV_SIGNED_EN
        qNeg_d   = signedOp_q & (dvdIn_q[DATA_WIDTH-1] ^ dvsIn_q[DATA_WIDTH-1]);
        rNeg_d   = signedOp_q & dvdIn_q[DATA_WIDTH-1];
        quo_d    = (signedOp_q && dvdIn_q[DATA_WIDTH-1]) ? -dvdIn_q : dvdIn_q;
        dvsMag_d = (signedOp_q && dvsIn_q[DATA_WIDTH-1]) ? -dvsIn_q : dvsIn_q;
`else
        quo_d    = dvdIn_q;
        dvsMag_d = dvsIn_q;
`endif
        rem_d   = '0;
        count_d = '0;
        state_d = ITER;
      end
      ITER: begin
        // remShift carries one extra bit, so the subtraction is exact whenever it is taken
        if (remShift >= {1'b0, dvsMag_q}) begin
          rem_d = remShift[DATA_WIDTH-1:0] - dvsMag_q;
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_d = remShift[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(DATA_WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (dvsIn_q == '0) begin
          quotient_d  = '1;
          remainder_d = dvdIn_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = quo_q;
          remainder_d = rem_q;
          dbz_d       = 1'b0;
`ifdef DIV_SIGNED_EN
          if (qNeg_q) quotient_d = -quo_q;
          if (rNeg_q) remainder_d = -rem_q;
`endif
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, negedge monitor pops on done.
// Follows DIV_SIGNED_EN the same way the design does.
module tb_seq_divider;

  localparam int W = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           doneCycle;
  } exp_t;

  logic         clock = 1'b0;
  logic         clear;
  logic         start;
  logic         signedOp;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int           vectors = 0;
  int           miscompares = 0;
  int           cycleCnt = 0;
  exp_t         expQ[$];
  logic [W-1:0] lastQ = '0;
  logic [W-1:0] lastR = '0;
  logic         lastDbz = 1'b0;
  logic         prevDone = 1'b0;

  seq_divider #(.DATA_WIDTH(W)) dut (
    .clock(clock),
    .clear(clear),
    .start(start),
    .signed_op(signedOp),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(dbz),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Reference: plain integer division, signed via 64-bit arithmetic (truncates toward zero)
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn, input int acceptCycle);
    exp_t   e;
    longint sa;
    longint sb;
    e.doneCycle = acceptCycle + LAT;
    e.dbz = (b == '0);
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
`ifdef DIV_SIGNED_EN
      if (sgn) begin
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.q = W'(sa / sb);
        e.r = W'(sa % sb);
      end
`else
      if (sgn) e.doneCycle = acceptCycle + LAT;
`endif
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Monitor: result checks on done, hold checks otherwise, done must be a single-cycle pulse
  always @(negedge clock) begin
    exp_t e;
    if (clear !== 1'b1) begin
      if (done) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpectedDone: got done=1, expected no result (cycle %0d)", cycleCnt);
        end else begin
          e = expQ.pop_front();
          checkOutput("quotient", quotient, e.q);
          checkOutput("remainder", remainder, e.r);
          checkOutput("divByZero", W'(dbz), W'(e.dbz));
          checkOutput("doneCycle", W'(cycleCnt), W'(e.doneCycle));
          lastQ   = e.q;
          lastR   = e.r;
          lastDbz = e.dbz;
        end
      end else begin
        checkOutput("holdQuotient", quotient, lastQ);
        checkOutput("holdRemainder", remainder, lastR);
        checkOutput("holdDivByZero", W'(dbz), W'(lastDbz));
      end
      if (prevDone) begin
        checkOutput("donePulse", W'(done), '0);
        checkOutput("busyAfterDone", W'(busy), '0);
      end
      prevDone = done;
    end else begin
      prevDone = 1'b0;
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL idleTimeout: got busy=1, expected 0 within 100 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    @(negedge clock);
    waitIdle();
    dividend = a;
    divisor  = b;
    signedOp = sgn;
    start    = 1'b1;
    expQ.push_back(model(a, b, sgn, cycleCnt + 1));
    @(negedge clock);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    signedOp = 1'($urandom);
  endtask

  task automatic waitResults();
    int n = 0;
    while (expQ.size() != 0 && n < 80) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL resultTimeout: got %0d pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish by 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    clear    = 1'b1;
    start    = 1'b0;
    signedOp = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    checkOutput("resetBusy", W'(busy), '0);
    checkOutput("resetDone", W'(done), '0);
    checkOutput("resetQuotient", quotient, '0);
    checkOutput("resetRemainder", remainder, '0);
    checkOutput("resetDivByZero", W'(dbz), '0);
    repeat (3) @(negedge clock);
    clear = 1'b0;

    applyStimulus(32'd100, 32'd7, 1'b0);
    waitResults();
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    waitResults();
    applyStimulus(32'd5, 32'd0, 1'b0);
    waitResults();
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitResults();
    applyStimulus(32'hFFFF_FFF0, 32'd0, 1'b1);
    waitResults();
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    waitResults();

    // A second start while busy must be dropped; any extra done trips the monitor
    applyStimulus(32'd9, 32'd3, 1'b0);
    repeat (8) @(negedge clock);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    waitResults();
    repeat (40) @(negedge clock);

    // Start raised while in DONE is only taken on the following IDLE edge
    applyStimulus(32'd1000, 32'd33, 1'b0);
    waitResults();
    dividend = 32'd77;
    divisor  = 32'd10;
    signedOp = 1'b0;
    start    = 1'b1;
    expQ.push_back(model(32'd77, 32'd10, 1'b0, cycleCnt + 2));
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    waitResults();

    // Asynchronous clear in the middle of the iteration
    applyStimulus(32'd123456, 32'd321, 1'b0);
    repeat (10) @(negedge clock);
    #2;
    clear = 1'b1;
    expQ.delete();
    lastQ   = '0;
    lastR   = '0;
    lastDbz = 1'b0;
    #1;
    checkOutput("clearBusy", W'(busy), '0);
    checkOutput("clearDone", W'(done), '0);
    checkOutput("clearQuotient", quotient, '0);
    checkOutput("clearRemainder", remainder, '0);
    checkOutput("clearDivByZero", W'(dbz), '0);
    @(negedge clock);
    clear = 1'b0;
    applyStimulus(32'd9, 32'd3, 1'b0);
    waitResults();

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      applyStimulus(a, b, 1'($urandom));
      waitResults();
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (5) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
